// File: rtl/primitive_matrix_decomp_arbiter.sv
// primitive_matrix_decomp_arbiter: round-robin sharing of one decomposition engine with stale-done masking and a job watchdog
module primitive_matrix_decomp_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] ack,
    output logic               ack_err,
    output logic [ID_W-1:0]    owner_id,
    output logic               busy,
    output logic               eng_start,
    input  logic               eng_done,
    output logic [CNT_W-1:0]   job_count,
    output logic [CNT_W-1:0]   err_count
);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, WAIT_CLR, RUN, DRAIN, GAP} state_t;

    state_t              state;
    logic [ID_W-1:0]     last_owner;
    logic [ID_W-1:0]     winner;
    logic [NUM_REQ-1:0]  hi;
    logic [NUM_REQ-1:0]  pool;
    logic [TW-1:0]       tcnt;
    logic                expire;

    // the counter value seen in the cycle that completes TIMEOUT_CYCLES in WAIT_CLR+RUN
    assign expire = (TIMEOUT_CYCLES != 0) && (tcnt == T_LAST);

    // round-robin pick: lowest requester above last_owner, else lowest overall
    always_comb begin
        hi     = req & ~((NUM_REQ'(2) << last_owner) - NUM_REQ'(1));
        pool   = (|hi) ? hi : req;
        winner = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) winner = pool[ID_W'(j)] ? ID_W'(j) : winner;
    end

    // job sequencer: grant, engine handshake, watchdog, completion routing and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= ID_W'(NUM_REQ - 1);
            tcnt       <= '0;
            grant      <= '0;
            ack        <= '0;
            ack_err    <= 1'b0;
            owner_id   <= '0;
            busy       <= 1'b0;
            eng_start  <= 1'b0;
            job_count  <= '0;
            err_count  <= '0;
        end else begin
            ack     <= '0;
            ack_err <= 1'b0;
            case (state)
                IDLE: if (|req) begin
                    grant      <= NUM_REQ'(1) << winner;
                    owner_id   <= winner;
                    last_owner <= winner;
                    eng_start  <= 1'b1;
                    busy       <= 1'b1;
                    tcnt       <= '0;
                    state      <= WAIT_CLR;
                end
                WAIT_CLR, RUN: begin
                    tcnt <= tcnt + TW'(1);
                    if (state == RUN && eng_done) begin
                        ack       <= grant;
                        job_count <= job_count + CNT_W'(1);
                        grant     <= '0;
                        eng_start <= 1'b0;
                        state     <= GAP;
                    end else if (expire) begin
                        ack       <= grant;
                        ack_err   <= 1'b1;
                        err_count <= (&err_count) ? err_count : err_count + CNT_W'(1);
                        grant     <= '0;
                        eng_start <= 1'b0;
                        state     <= (state == RUN) ? DRAIN : GAP;
                    end else if (state == WAIT_CLR && !eng_done) begin
                        state <= RUN;
                    end
                end
                DRAIN: if (eng_done) state <= GAP;
                GAP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_primitive_matrix_decomp_arbiter.sv
// tb_primitive_matrix_decomp_arbiter: table-driven job sequence with an engine model and completion scoreboard
module tb_primitive_matrix_decomp_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] ack;
    logic       ack_err;
    logic [1:0] owner_id;
    logic       busy;
    logic       eng_start;
    logic       eng_done;
    logic [15:0] job_count;
    logic [15:0] err_count;

    primitive_matrix_decomp_arbiter #(
        .NUM_REQ(4), .ID_W(2), .TIMEOUT_CYCLES(64), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .ack(ack),
        .ack_err(ack_err), .owner_id(owner_id), .busy(busy),
        .eng_start(eng_start), .eng_done(eng_done),
        .job_count(job_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // engine model: done stays at its old level until the start rise has been
    // taken, drops, then rises lat cycles later and holds until the next start
    int   lat = 10;
    logic stuck = 1'b0;
    logic done_r;
    logic prev_start;
    int   ecnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r     <= 1'b0;
            prev_start <= 1'b0;
            ecnt       <= 0;
        end else begin
            prev_start <= eng_start;
            if (eng_start && !prev_start) ecnt <= lat;
            else if (ecnt > 0) begin
                ecnt   <= ecnt - 1;
                done_r <= (ecnt == 1);
            end
        end
    end
    assign eng_done = stuck | done_r;

    typedef struct {
        logic [3:0] req;
        int         lat;
        logic       stuck;
        logic       drop;
        int         owner;
        logic       err;
        int         dur;
        int         gap;
    } vec_t;

    typedef struct {
        logic [3:0] ack;
        logic       err;
        int         owner;
    } exp_t;

    vec_t vt[13];
    exp_t sb[$];
    exp_t e;
    int checks = 0;
    int errors = 0;
    int exp_jobs = 0;
    int exp_errs = 0;
    int grant_cyc, ack_cyc, n, bad;
    logic [3:0] oh;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_grant();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == 4'b0 && n < 1000);
        grant_cyc = cyc;
    endtask

    task automatic wait_ack(input logic [3:0] g);
        n = 0;
        bad = 0;
        while (ack == 4'b0 && n < 1000) begin
            if (ack_err || grant != g) bad++;
            @(negedge clk);
            n++;
        end
        ack_cyc = cyc;
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{4'b0, 1'b0, -1};
        chk("ack", ack, e.ack);
        chk("ack_err", ack_err, e.err);
        chk("owner_id", owner_id, e.owner);
        chk("hold_until_ack", bad, 0);
    endtask

    initial begin
        vt[0]  = '{4'b1111, 10,  1'b0, 1'b0, 0, 1'b0, 12, -1};
        vt[1]  = '{4'b1111, 10,  1'b0, 1'b0, 1, 1'b0, 12, 2};
        vt[2]  = '{4'b1111, 10,  1'b0, 1'b0, 2, 1'b0, 12, 2};
        vt[3]  = '{4'b1111, 10,  1'b0, 1'b0, 3, 1'b0, 12, 2};
        vt[4]  = '{4'b1111, 10,  1'b0, 1'b0, 0, 1'b0, 12, 2};
        vt[5]  = '{4'b0010, 10,  1'b0, 1'b1, 1, 1'b0, 12, 2};
        vt[6]  = '{4'b0100, 200, 1'b0, 1'b0, 2, 1'b1, 64, 2};
        vt[7]  = '{4'b1000, 62,  1'b0, 1'b0, 3, 1'b0, 64, 140};
        vt[8]  = '{4'b0001, 63,  1'b0, 1'b0, 0, 1'b1, 64, 2};
        vt[9]  = '{4'b0010, 10,  1'b0, 1'b0, 1, 1'b0, 12, 3};
        vt[10] = '{4'b0100, 10,  1'b1, 1'b0, 2, 1'b1, 64, 2};
        vt[11] = '{4'b0100, 10,  1'b0, 1'b0, 2, 1'b0, 12, 2};
        vt[12] = '{4'b0110, 10,  1'b0, 1'b0, 1, 1'b0, 12, 2};

        rst_n = 1'b0;
        req   = 4'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_ack", ack, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_owner_id", owner_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_job_count", job_count, 0);
        chk("rst_err_count", err_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            req   = vt[i].req;
            lat   = vt[i].lat;
            stuck = vt[i].stuck;
            oh    = 4'b0001 << vt[i].owner;
            sb.push_back('{oh, vt[i].err, vt[i].owner});
            wait_grant();
            chk($sformatf("grant_v%0d", i), grant, oh);
            chk($sformatf("eng_start_v%0d", i), eng_start, 1);
            if (vt[i].gap < 0) chk("req_to_grant", n, 1);
            else chk($sformatf("ack_to_grant_v%0d", i), grant_cyc - ack_cyc, vt[i].gap);
            if (vt[i].drop) req = 4'b0;
            wait_ack(oh);
            if (vt[i].err) exp_errs++;
            else exp_jobs++;
            chk($sformatf("duration_v%0d", i), ack_cyc - grant_cyc, vt[i].dur);
            chk($sformatf("job_count_v%0d", i), job_count, exp_jobs);
            chk($sformatf("err_count_v%0d", i), err_count, exp_errs);
            chk($sformatf("busy_at_ack_v%0d", i), busy, 1);
        end

        req   = 4'b0100;
        lat   = 10;
        stuck = 1'b0;
        wait_grant();
        chk("pre_reset_grant", grant, 4'b0100);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_rst_grant", grant, 0);
        chk("midrun_rst_eng_start", eng_start, 0);
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_job_count", job_count, 0);
        sb.delete();
        exp_jobs = 0;
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;
        sb.push_back('{4'b0001, 1'b0, 0});
        wait_grant();
        chk("post_reset_grant", grant, 4'b0001);
        chk("post_reset_latency", n, 1);
        req = 4'b0;
        wait_ack(4'b0001);
        chk("post_reset_job_count", job_count, 1);
        @(negedge clk);
        chk("ack_one_cycle", ack, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/primitive_matrix_decomp_arbiter.md
Name: primitive_matrix_decomp_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one primitive_matrix_decomp engine among NUM_REQ requesters, e.g. partitioning workers in the Forge.
- Owns the engine's level-sensitive start/done handshake and masks the engine's stale done level.
- Enforces a watchdog timeout per job.
- Routes completion (ack or error) back to the owning requester, and keeps job and error counters for status readout.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- ID_W, 2, width of owner index; equals ceil(log2(NUM_REQ))
- TIMEOUT_CYCLES, 4096, maximum cycles in WAIT_CLR+RUN before abort; 0 disables the watchdog
- CNT_W, 16, width of job and error counters

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester request level; held until ack
- grant  out  NUM_REQ  one-hot owner of the engine; 0 when idle
- ack  out  NUM_REQ  one-cycle pulse to owner at job end
- ack_err  out  1  qualifies ack: 1 = job aborted by timeout
- owner_id  out  ID_W  index of current or last owner
- busy  out  1  high in any state other than IDLE
- eng_start  out  1  drives engine start (level)
- eng_done  in  1  engine done (level; stale-high after completion until next start)
- job_count  out  CNT_W  jobs completed normally, wraps
- err_count  out  CNT_W  jobs aborted by timeout, saturates at all-ones

Behaviour:
- Reset values: all outputs 0. Internal last_owner resets to NUM_REQ-1, so requester 0 has first priority. State resets to IDLE and the timeout counter to 0.
- Reset mid-job: eng_start drops immediately. The engine has its own reset and is expected to reset alongside this block.
- States: IDLE, WAIT_CLR, RUN, DRAIN, GAP. All outputs are registered.
- IDLE, when req != 0:
  - Winner is the first set bit searching from last_owner+1 upward, wrapping modulo NUM_REQ.
  - Next cycle: grant = onehot(winner), owner_id = winner, last_owner = winner, eng_start = 1, timeout counter cleared, go to WAIT_CLR.
  - Latency from req sampled to grant/eng_start is 1 cycle.
- WAIT_CLR: eng_done is ignored until it is seen low, because the engine holds the previous done for one cycle after start. On eng_done == 0, go to RUN.
- RUN, on eng_done == 1:
  - ack[owner] pulses for 1 cycle with ack_err = 0; job_count increments.
  - grant = 0 and eng_start = 0, all in the same cycle; go to GAP.
- Timeout: the counter increments every cycle in WAIT_CLR and RUN. On reaching TIMEOUT_CYCLES (nonzero):
  - ack[owner] pulses with ack_err = 1; err_count increments (saturating).
  - grant = 0 and eng_start = 0.
  - From RUN, go to DRAIN. From WAIT_CLR (done stuck high, engine never restarted), go to GAP.
- DRAIN: the engine cannot be aborted mid-iteration, so busy stays 1 and no grant is issued. On eng_done == 1, go to GAP. DRAIN has no timeout.
- GAP: exactly 1 cycle with eng_start low, letting the engine return from COMPLETE to IDLE. Then go to IDLE.
- Minimum back-to-back spacing: the next grant is at least 2 cycles after ack.
- Requester rules:
  - Dropping req while granted does not cancel the job; ack still pulses.
  - A req still high in IDLE after its own ack counts as a new request, but it sits behind the other requesters in round-robin order.
  - A req asserted in the same cycle as another's ack waits for IDLE.
- Simultaneous eng_done == 1 and timeout expiry in RUN: normal completion wins (ack_err = 0, no error count).
- ack and ack_err are 0 in every cycle other than the completion cycle. grant is never multi-hot.

Test Plan:
- Setup for all scenarios: NUM_REQ = 4, TIMEOUT_CYCLES = 64, engine model with 10-cycle latency and stale done.
- Single job: req = 4'b0010 at cycle 0 -> grant = 4'b0010 and eng_start = 1 at cycle 1. WAIT_CLR passes on done low. ack = 4'b0010 with ack_err = 0 when done rises. job_count = 1. Next IDLE after 1 GAP cycle.
- Round robin: req = 4'b1111 held -> grants issued in order 0, 1, 2, 3, 0 across consecutive jobs. Each grant comes 2 cycles after the previous ack.
- Stale done: engine holds done = 1 for 1 cycle after eng_start rises -> no premature ack. ack occurs only after the real completion.
- Timeout: engine latency 200 -> ack_err = 1 with ack at the 64th WAIT_CLR+RUN cycle; err_count = 1; state DRAIN with busy = 1 until done, then GAP, then IDLE. No grant issued during DRAIN.
- Coincident done and timeout: done rises exactly on the expiry cycle -> ack_err = 0, job_count increments, err_count unchanged.
- Reset mid-RUN: assert rst_n = 0 -> grant, eng_start and busy read 0 immediately. After release, requester 0 wins first.
